// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage and the instruction memory.
// Single outstanding word request; address held stable until ack.
// Signal names are from the fetch stage's point of view.
interface fetch_stage_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;

    // Fetch stage side: issues requests, receives data.
    modport master (
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_ack,
        input  i_imem_rdata
    );

    // Memory side: accepts requests, returns data.
    modport slave (
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_ack,
        output i_imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Purpose: RV32I instruction fetch (PC, imem req/ack) plus the IF/ID pipeline register.
// Latency: a fetched word reaches IF/ID on the clock edge that samples its ack.
// Backpressure: i_stall freezes IF/ID; a word acked during stall parks in a one-entry hold buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_stall,
    input  logic          i_pc_sel,
    input  logic [31:0]   i_alu_data,
    fetch_stage_if.master imem,
    output logic [31:0]   o_pc,
    output logic [31:0]   o_pc_four,
    output logic [31:0]   o_instr,
    output logic          o_insn_vld
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic        hold_vld;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic [31:0] target;
    logic [31:0] pc_next_seq;

    // Redirect targets are always word aligned; the low ALU bits are ignored.
    assign target      = i_alu_data & 32'hFFFF_FFFC;
    assign pc_next_seq = pc + 32'd4;

    // The request is suppressed while parked and during reset; in S_DROP the
    // address must stay on the abandoned request until memory acks it.
    assign imem.o_imem_req  = !i_reset && (state != S_HOLD);
    assign imem.o_imem_addr = (state == S_DROP) ? drop_addr : pc;

    assign o_pc_four = o_pc + 32'd4;

    // Fetch FSM: PC sequencing, redirect handling and the stall hold buffer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            drop_addr  <= RESET_PC;
            hold_vld   <= 1'b0;
            hold_instr <= NOP_INSN;
            hold_pc    <= RESET_PC;
        end else begin
            case (state)
                S_REQ: begin
                    if (i_pc_sel) begin
                        pc       <= target;
                        hold_vld <= 1'b0;
                        if (!imem.i_imem_ack) begin
                            // Request still in flight: its data must be thrown away.
                            drop_addr <= pc;
                            state     <= S_DROP;
                        end
                    end else if (imem.i_imem_ack) begin
                        pc <= pc_next_seq;
                        if (i_stall) begin
                            hold_vld   <= 1'b1;
                            hold_instr <= imem.i_imem_rdata;
                            hold_pc    <= pc;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_pc_sel) begin
                        pc       <= target;
                        hold_vld <= 1'b0;
                        state    <= S_REQ;
                    end else if (!i_stall) begin
                        hold_vld <= 1'b0;
                        state    <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (i_pc_sel) begin
                        pc <= target;
                    end
                    // Once the stale request completes, the next request uses pc,
                    // which already holds the most recent target.
                    if (imem.i_imem_ack) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // IF/ID register: redirect flushes, stall holds, else load or insert a bubble.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_insn_vld <= 1'b0;
            o_instr    <= NOP_INSN;
            o_pc       <= 32'd0;
        end else if (i_pc_sel) begin
            o_insn_vld <= 1'b0;
            o_instr    <= NOP_INSN;
        end else if (i_stall) begin
            o_insn_vld <= o_insn_vld;
        end else if ((state == S_REQ) && imem.i_imem_ack) begin
            o_insn_vld <= 1'b1;
            o_instr    <= imem.i_imem_rdata;
            o_pc       <= pc;
        end else if ((state == S_HOLD) && hold_vld) begin
            o_insn_vld <= 1'b1;
            o_instr    <= hold_instr;
            o_pc       <= hold_pc;
        end else begin
            o_insn_vld <= 1'b0;
            o_instr    <= NOP_INSN;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queue-based scoreboard.
// Stimulus is applied and outputs sampled on the falling clock edge.
// The monitor pops one expected (pc, instr) whenever IF/ID presents a new valid slot.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        i_clk;
    logic        i_reset;
    logic        i_stall;
    logic        i_pc_sel;
    logic [31:0] i_alu_data;
    logic [31:0] o_pc;
    logic [31:0] o_pc_four;
    logic [31:0] o_instr;
    logic        o_insn_vld;

    fetch_stage_if imem ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSN (NOP)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_stall    (i_stall),
        .i_pc_sel   (i_pc_sel),
        .i_alu_data (i_alu_data),
        .imem       (imem.master),
        .o_pc       (o_pc),
        .o_pc_four  (o_pc_four),
        .o_instr    (o_instr),
        .o_insn_vld (o_insn_vld)
    );

    int   total;
    int   bad;
    exp_t sb[$];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Instruction memory contents: word at 8 is addi x1,x0,5, others tagged by address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'h8) w = 32'h0050_0093;
        else            w = {a[23:0], 8'h13};
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then advance to the next falling edge.
    task automatic drive(input logic rst, input logic stall, input logic sel,
                         input logic [31:0] alu, input logic ack);
        i_reset         = rst;
        i_stall         = stall;
        i_pc_sel        = sel;
        i_alu_data      = alu;
        imem.i_imem_ack = ack;
        imem.i_imem_rdata = ack ? mem(imem.o_imem_addr) : 32'hDEAD_BEEF;
        if (rst) begin
            #1;
            chk("req_during_reset", {31'd0, imem.o_imem_req}, 32'd0);
        end
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = mem(a);
        sb.push_back(e);
    endtask

    // Monitor: a slot is new when valid after an edge that was not stalled or in reset.
    initial begin
        logic st;
        logic rs;
        exp_t e;
        forever begin
            @(posedge i_clk);
            st = i_stall;
            rs = i_reset;
            @(negedge i_clk);
            if (o_insn_vld && !st && !rs) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_unexpected: got vld pc=%h instr=%h expected none at %0t",
                             o_pc, o_instr, $time);
                end else begin
                    e = sb.pop_front();
                    chk("mon_pc", o_pc, e.pc);
                    chk("mon_instr", o_instr, e.instr);
                    chk("mon_pc_four", o_pc_four, e.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        i_reset = 1'b1;
        i_stall = 1'b0;
        i_pc_sel = 1'b0;
        i_alu_data = 32'd0;
        imem.i_imem_ack = 1'b0;
        imem.i_imem_rdata = 32'd0;
        @(negedge i_clk);

        // Reset state
        do_reset();
        chk("rst_vld", {31'd0, o_insn_vld}, 32'd0);
        chk("rst_instr", o_instr, NOP);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_pc_four", o_pc_four, 32'd4);

        // Zero-wait stream: one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            chk("zw_addr", imem.o_imem_addr, 32'(i * 4));
            push(32'(i * 4));
            drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
            if (i == 0) chk("zw_first_vld", {31'd0, o_insn_vld}, 32'd1);
        end
        chk("zw_next_addr", imem.o_imem_addr, 32'h10);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("zw_bubble_vld", {31'd0, o_insn_vld}, 32'd0);
        chk("zw_bubble_instr", o_instr, NOP);

        // Three wait cycles per fetch: address stable, bubbles between
        for (int f = 0; f < 2; f++) begin
            for (int w = 0; w < 3; w++) begin
                chk("ws_addr_stable", imem.o_imem_addr, 32'h10 + 32'(f * 4));
                chk("ws_req", {31'd0, imem.o_imem_req}, 32'd1);
                drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
                chk("ws_bubble_vld", {31'd0, o_insn_vld}, 32'd0);
                chk("ws_bubble_instr", o_instr, NOP);
            end
            push(32'h10 + 32'(f * 4));
            drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        end

        // Stall coinciding with ack for pc=8 goes through the hold buffer
        do_reset();
        push(32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        push(32'h4);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("st_addr", imem.o_imem_addr, 32'h8);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("st_hold_pc", o_pc, 32'h4);
        chk("st_hold_vld", {31'd0, o_insn_vld}, 32'd1);
        chk("st_req_low", {31'd0, imem.o_imem_req}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("st_req_low2", {31'd0, imem.o_imem_req}, 32'd0);
        chk("st_hold_instr", o_instr, mem(32'h4));
        push(32'h8);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("st_rel_pc", o_pc, 32'h8);
        chk("st_rel_instr", o_instr, 32'h0050_0093);
        chk("st_rel_addr", imem.o_imem_addr, 32'hC);
        chk("st_rel_req", {31'd0, imem.o_imem_req}, 32'd1);

        // Redirect with same-cycle ack: data discarded, unaligned target aligned
        drive(1'b0, 1'b0, 1'b1, 32'h103, 1'b1);
        chk("rd_vld", {31'd0, o_insn_vld}, 32'd0);
        chk("rd_instr", o_instr, NOP);
        chk("rd_addr", imem.o_imem_addr, 32'h100);
        push(32'h100);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect while request for 0x10 is waiting: stale data dropped
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(32'(i * 4));
            drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        end
        chk("dr_addr_wait", imem.o_imem_addr, 32'h10);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        chk("dr_addr_held", imem.o_imem_addr, 32'h10);
        chk("dr_req", {31'd0, imem.o_imem_req}, 32'd1);
        chk("dr_vld", {31'd0, o_insn_vld}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("dr_addr_held2", imem.o_imem_addr, 32'h10);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("dr_addr_target", imem.o_imem_addr, 32'h200);
        chk("dr_no_vld", {31'd0, o_insn_vld}, 32'd0);
        push(32'h200);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // PC wrap: redirect to the last word, pc+4 wraps to zero
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        chk("wr_addr", imem.o_imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("wr_pc_four", o_pc_four, 32'h0);
        chk("wr_next_addr", imem.o_imem_addr, 32'h0);

        // Reset while parked in the hold buffer: buffered word never appears
        do_reset();
        push(32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rh_addr", imem.o_imem_addr, 32'h4);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("rh_vld", {31'd0, o_insn_vld}, 32'd0);
        chk("rh_instr", o_instr, NOP);
        chk("rh_pc", o_pc, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("rh_post_vld", {31'd0, o_insn_vld}, 32'd0);
        chk("rh_post_addr", imem.o_imem_addr, 32'h0);
        chk("rh_post_req", {31'd0, imem.o_imem_req}, 32'd1);
        push(32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rh_refetch_vld", {31'd0, o_insn_vld}, 32'd1);

        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
